// File: rtl/rv_wb_stage.sv
// Write-back stage: selects the register-file write value and enables, keeps a
// one-cycle registered forwarding copy, and counts retired instructions.
module rv_wb_stage #(
  parameter int unsigned CW             = 16,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned MEM_TO_REG_BIT = 2,
  parameter int unsigned REG_WRITE_BIT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_mem_data,
  input  logic [CW-1:0]    mem_control_signals,
  input  logic [4:0]       mem_rd,
  input  logic             mem_valid,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [XLEN-1:0]  wb_fwd_data,
  output logic [4:0]       wb_fwd_rd,
  output logic             wb_fwd_valid,
  output logic [CNT_W-1:0] wb_instret
);

  localparam int unsigned RD_W = 5;

  logic mem_to_reg;
  logic reg_write_bit;
  logic reg_write_known;

  assign mem_to_reg    = mem_control_signals[MEM_TO_REG_BIT];
  assign reg_write_bit = mem_control_signals[REG_WRITE_BIT];

  // Case with a zero default so an unknown select never leaks X downstream.
  always_comb begin
    wb_data = '0;
    case (mem_to_reg)
      1'b0:    wb_data = mem_alu_result;
      1'b1:    wb_data = mem_mem_data;
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    reg_write_known = 1'b0;
    case (reg_write_bit)
      1'b1:    reg_write_known = 1'b1;
      default: reg_write_known = 1'b0;
    endcase
  end

  // x0 is hard-wired zero, so it is never a write target.
  assign wb_reg_write = mem_valid & reg_write_known & (mem_rd != RD_W'(0));
  assign wb_rd        = mem_rd;

  // Forwarding copy covers read-during-write for the instruction one cycle behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_fwd_data  <= '0;
      wb_fwd_rd    <= '0;
      wb_fwd_valid <= 1'b0;
    end else begin
      wb_fwd_data  <= wb_data;
      wb_fwd_rd    <= wb_rd;
      wb_fwd_valid <= wb_reg_write;
    end
  end

  // Every valid slot retires, regardless of whether it writes a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_instret <= '0;
    end else if (mem_valid) begin
      wb_instret <= wb_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_wb_stage.sv
// Directed bench for rv_wb_stage: mux select, write enable, forwarding copy,
// retire counter and asynchronous reset behaviour.
module tb_rv_wb_stage;

  localparam int unsigned CW    = 16;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;
  localparam int unsigned M2R   = 2;
  localparam int unsigned RW    = 3;

  logic             clk;
  logic             rst_n;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_mem_data;
  logic [CW-1:0]    mem_control_signals;
  logic [4:0]       mem_rd;
  logic             mem_valid;
  logic [XLEN-1:0]  wb_data;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic [XLEN-1:0]  wb_fwd_data;
  logic [4:0]       wb_fwd_rd;
  logic             wb_fwd_valid;
  logic [CNT_W-1:0] wb_instret;

  int n_assert = 0;
  int n_fail   = 0;

  rv_wb_stage #(
    .CW(CW), .XLEN(XLEN), .CNT_W(CNT_W), .MEM_TO_REG_BIT(M2R), .REG_WRITE_BIT(RW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_alu_result      (mem_alu_result),
    .mem_mem_data        (mem_mem_data),
    .mem_control_signals (mem_control_signals),
    .mem_rd              (mem_rd),
    .mem_valid           (mem_valid),
    .wb_data             (wb_data),
    .wb_rd               (wb_rd),
    .wb_reg_write        (wb_reg_write),
    .wb_fwd_data         (wb_fwd_data),
    .wb_fwd_rd           (wb_fwd_rd),
    .wb_fwd_valid        (wb_fwd_valid),
    .wb_instret          (wb_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    mem_alu_result      = '0;
    mem_mem_data        = '0;
    mem_control_signals = '0;
    mem_rd              = '0;
    mem_valid           = 1'b0;

    // Reset state, after an edge has passed with rst_n low.
    @(posedge clk); #1;
    chk("rst_fwd_data",  64'(wb_fwd_data),  64'h0);
    chk("rst_fwd_rd",    64'(wb_fwd_rd),    64'h0);
    chk("rst_fwd_valid", 64'(wb_fwd_valid), 64'h0);
    chk("rst_instret",   wb_instret,        64'h0);

    // Combinational paths follow inputs even while reset is held.
    mem_alu_result = 32'hDEAD_BEEF;
    mem_mem_data   = 32'hCAFE_BABE;
    #1;
    chk("sel_alu", 64'(wb_data), 64'h0000_0000_DEAD_BEEF);
    mem_control_signals[M2R] = 1'b1;
    #1;
    chk("sel_mem", 64'(wb_data), 64'h0000_0000_CAFE_BABE);
    mem_alu_result = '0;
    mem_mem_data   = '0;
    mem_control_signals[M2R] = 1'bx;
    #1;
    chk("sel_x_zero", 64'(wb_data), 64'h0);

    mem_alu_result           = 32'hDEAD_BEEF;
    mem_mem_data             = 32'hCAFE_BABE;
    mem_control_signals[M2R] = 1'b0;
    mem_control_signals[RW]  = 1'b1;
    mem_valid                = 1'b1;
    mem_rd                   = 5'd5;
    #1;
    chk("we_rd5",   64'(wb_reg_write), 64'h1);
    chk("wb_rd5",   64'(wb_rd),        64'h5);
    mem_rd = 5'd0;
    #1;
    chk("we_rd0",   64'(wb_reg_write), 64'h0);
    mem_rd    = 5'd7;
    mem_valid = 1'b0;
    #1;
    chk("we_bubble", 64'(wb_reg_write), 64'h0);
    mem_valid = 1'b1;
    mem_control_signals[RW] = 1'b0;
    #1;
    chk("we_norw",  64'(wb_reg_write), 64'h0);
    mem_control_signals[RW] = 1'bx;
    #1;
    chk("we_x_rw",  64'(wb_reg_write), 64'h0);

    // Still in reset after another edge with valid high: nothing captured.
    @(posedge clk); #1;
    chk("rst_hold_instret", wb_instret,       64'h0);
    chk("rst_hold_fwd_rd",  64'(wb_fwd_rd),   64'h0);

    // Release reset; first capture on the next rising edge.
    @(negedge clk);
    rst_n                   = 1'b1;
    mem_control_signals[RW] = 1'b1;
    mem_rd                  = 5'd5;
    mem_valid               = 1'b1;
    @(posedge clk); #1;
    chk("fwd_data1",  64'(wb_fwd_data),  64'h0000_0000_DEAD_BEEF);
    chk("fwd_rd1",    64'(wb_fwd_rd),    64'h5);
    chk("fwd_valid1", 64'(wb_fwd_valid), 64'h1);
    chk("instret1",   wb_instret,        64'h1);

    // Second valid edge: load via MEM_TO_REG to x0, so no write is forwarded.
    @(negedge clk);
    mem_control_signals[M2R] = 1'b1;
    mem_rd                   = 5'd0;
    @(posedge clk); #1;
    chk("fwd_data2",  64'(wb_fwd_data),  64'h0000_0000_CAFE_BABE);
    chk("fwd_rd2",    64'(wb_fwd_rd),    64'h0);
    chk("fwd_valid2", 64'(wb_fwd_valid), 64'h0);

    // Third valid edge is a store (no REG_WRITE) that still retires.
    @(negedge clk);
    mem_control_signals[RW] = 1'b0;
    mem_rd                  = 5'd9;
    @(posedge clk); #1;
    chk("fwd_valid3", 64'(wb_fwd_valid), 64'h0);
    chk("instret3",   wb_instret,        64'h3);

    // Two bubble edges: counter holds.
    @(negedge clk);
    mem_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("instret_hold", wb_instret,     64'h3);
    chk("fwd_rd_bub",   64'(wb_fwd_rd), 64'h9);

    // Asynchronous reset between edges clears state immediately.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_instret",   wb_instret,        64'h0);
    chk("arst_fwd_data",  64'(wb_fwd_data),  64'h0);
    chk("arst_fwd_rd",    64'(wb_fwd_rd),    64'h0);
    chk("arst_fwd_valid", 64'(wb_fwd_valid), 64'h0);

    // Mid-stream release: counting resumes from zero.
    @(negedge clk);
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    chk("instret_after_rst", wb_instret, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
